// File: rtl/fns_dec_pkg.sv
// rtl/fns_dec_pkg.sv - shared constants and state encoding for the FNS decode sequencer
package fns_dec_pkg;

  localparam int CW = 9;  // bits per CAC code group
  localparam int NW = 7;  // programmable weights, code bits 2..8

  localparam int FNS03 = 2;
  localparam int FNS04 = 3;
  localparam int FNS05 = 5;
  localparam int FNS06 = 8;
  localparam int FNS07 = 13;
  localparam int FNS08 = 21;
  localparam int FNS09 = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Reset value of programmable weight idx (idx 0 belongs to code bit 2).
  function automatic int default_weight(input int idx);
    case (idx)
      0:       return FNS03;
      1:       return FNS04;
      2:       return FNS05;
      3:       return FNS06;
      4:       return FNS07;
      5:       return FNS08;
      default: return FNS09;
    endcase
  endfunction

endpackage

// File: rtl/fns_group_dec.sv
// rtl/fns_group_dec.sv - combinational decode of one masked 9-bit FNS code group
module fns_group_dec
  import fns_dec_pkg::*;
#(
  parameter int WLEN = 8,
  parameter int BLEN = 8
) (
  input  logic [CW-1:0]      code_i,
  input  logic [CW-1:0]      mask_i,
  input  logic [NW*WLEN-1:0] wgt_i,
  output logic [BLEN-1:0]    res_o
);

  logic [CW-1:0]   en_bits;
  logic [BLEN-1:0] acc;

  // Bits 0/1 weigh 1, bits 2..8 take their programmed weight; sum wraps at BLEN bits.
  always_comb begin
    en_bits = code_i & mask_i;
    acc     = BLEN'(en_bits[0]) + BLEN'(en_bits[1]);
    for (int i = 0; i < NW; i++) begin
      if (en_bits[i+2]) begin
        acc = acc + BLEN'(wgt_i[i*WLEN +: WLEN]);
      end
    end
  end

  assign res_o = acc;

endmodule

// File: rtl/fns_dec_seq.sv
// rtl/fns_dec_seq.sv - one-group-per-cycle FNS codeword decode sequencer
module fns_dec_seq
  import fns_dec_pkg::*;
#(
  parameter int NGRP = 4,
  parameter int WLEN = 8,
  parameter int BLEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NGRP*CW-1:0]   in_code,
  input  logic [NGRP*CW-1:0]   in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NGRP*BLEN-1:0] out_data,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [WLEN-1:0]      cfg_wdata,
  output logic                 cfg_drop,
  output logic                 busy
);

  localparam int CNTW = (NGRP > 1) ? $clog2(NGRP) : 1;

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [NGRP*CW-1:0]    code_q, code_d;
  logic [NGRP*CW-1:0]    mask_q, mask_d;
  logic [NGRP*BLEN-1:0]  data_q, data_d;
  logic [NW*WLEN-1:0]    wgt_q, wgt_d;
  logic                  drop_q, drop_d;

  logic [CW-1:0]         grp_code;
  logic [CW-1:0]         grp_mask;
  logic [BLEN-1:0]       grp_res;

  assign grp_code = code_q[cnt_q*CW +: CW];
  assign grp_mask = mask_q[cnt_q*CW +: CW];

  fns_group_dec #(
    .WLEN (WLEN),
    .BLEN (BLEN)
  ) u_group_dec (
    .code_i (grp_code),
    .mask_i (grp_mask),
    .wgt_i  (wgt_q),
    .res_o  (grp_res)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign cfg_drop  = drop_q;

  // Next-state: accept in IDLE, walk groups in DEC, hold result in OUT; weight writes only land in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    mask_d  = mask_q;
    data_d  = data_q;
    wgt_d   = wgt_q;
    drop_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d  = in_code;
          mask_d  = in_mask;
          cnt_d   = '0;
          state_d = DEC;
        end
      end
      DEC: begin
        data_d[cnt_q*BLEN +: BLEN] = grp_res;
        if (cnt_q == CNTW'(NGRP - 1)) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Address 7 has no weight behind it and is ignored without a drop pulse.
    if (cfg_we && (cfg_addr < 3'(NW))) begin
      if (state_q == IDLE) begin
        wgt_d[cfg_addr*WLEN +: WLEN] = cfg_wdata;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // State register; reset discards any codeword in flight and restores default weights.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        wgt_q[i*WLEN +: WLEN] <= WLEN'(default_weight(i));
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      wgt_q   <= wgt_d;
    end
  end

endmodule

// File: tb/tb_fns_dec_seq.sv
// tb/tb_fns_dec_seq.sv - scoreboard bench for fns_dec_seq with a bit-weight reference model
`timescale 1ns/1ps
module tb_fns_dec_seq;

  localparam int NGRP = 4;
  localparam int WLEN = 8;
  localparam int BLEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] in_code = '0;
  logic [35:0] in_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        cfg_drop;
  logic        busy;

  int nvec = 0;
  int errs = 0;
  int wm[9];
  logic [31:0] sb_q[$];

  localparam logic [35:0] ALL1 = {4{9'h1FF}};

  fns_dec_seq #(.NGRP(NGRP), .WLEN(WLEN), .BLEN(BLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_drop  (cfg_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    wm = '{1, 1, 2, 3, 5, 8, 13, 21, 34};
  endfunction

  function automatic void model_cfg(input logic [2:0] a, input logic [7:0] d);
    if (a < 3'd7) wm[int'(a) + 2] = int'(d);
  endfunction

  function automatic logic [31:0] model_word(input logic [35:0] code, input logic [35:0] mask);
    logic [31:0] r;
    int s;
    r = '0;
    for (int g = 0; g < NGRP; g++) begin
      s = 0;
      for (int b = 0; b < 9; b++)
        if (code[9*g+b] && mask[9*g+b]) s += wm[b];
      r[8*g +: 8] = 8'(s % 256);
    end
    return r;
  endfunction

  // Monitor: every output handshake pops one expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        nvec++;
        errs++;
        $display("FAIL sb_underflow: got word %0h with nothing expected", out_data);
      end else begin
        chk("sb_out_data", out_data, sb_q.pop_front());
      end
    end
  end

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    model_cfg(a, d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    chk("idle_no_drop", cfg_drop, 0);
  endtask

  task automatic run_word(input logic [35:0] code, input logic [35:0] mask,
                          input int stall, input bit dec_wr, input bit same_wr);
    logic [31:0] exp;
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("idle_ready", in_ready, 1);
    in_code = code; in_mask = mask; in_valid = 1'b1;
    if (same_wr) begin
      cfg_addr = 3'($urandom_range(0, 7)); cfg_wdata = 8'($urandom); cfg_we = 1'b1;
      model_cfg(cfg_addr, cfg_wdata);
    end
    exp = model_word(code, mask);
    sb_q.push_back(exp);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    chk("dec_busy", busy, 1);
    chk("dec_in_ready", in_ready, 0);
    chk("dec_out_valid", out_valid, 0);
    for (int c = 1; c <= NGRP; c++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("latency_valid", out_valid, (c == NGRP));
      if (dec_wr && c == 1) begin cfg_addr = 3'd0; cfg_wdata = 8'd99; cfg_we = 1'b1; end
      if (dec_wr && c == 2) begin cfg_we = 1'b0; chk("drop_pulse", cfg_drop, 1); end
      if (dec_wr && c == 3) chk("drop_clear", cfg_drop, 0);
    end
    chk("out_data", out_data, exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_data_kept", out_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_drop", cfg_drop, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1);

    // Defaults: 88 per group.
    run_word(ALL1, ALL1, 0, 0, 0);
    // Masked group 1.
    run_word({9'h000, 9'h000, 9'h1FF, 9'h004}, {9'h1FF, 9'h1FF, 9'h000, 9'h1FF}, 0, 0, 0);
    // Bit-8 weight reprogramming and wrap.
    cfg_write(3'd6, 8'd200);
    run_word(ALL1, ALL1, 0, 0, 0);
    cfg_write(3'd6, 8'd255);
    run_word(ALL1, ALL1, 0, 0, 0);
    // Back-pressure: six OUT cycles with out_ready low.
    run_word(ALL1, ALL1, 5, 0, 0);
    // Dropped write during DEC, then weight unchanged.
    run_word({4{9'h004}}, ALL1, 0, 1, 0);
    run_word({27'h0, 9'h004}, ALL1, 0, 0, 0);
    // Address 7 ignored silently.
    cfg_write(3'd7, 8'd123);
    run_word(ALL1, ALL1, 1, 0, 0);

    // Reset in the second DEC cycle.
    cfg_write(3'd3, 8'd77);
    in_code = ALL1; in_mask = ALL1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_ready_back", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", out_valid, 0);
    end
    run_word(ALL1, ALL1, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [35:0] rc, rm;
      rc = {4'($urandom), 32'($urandom)};
      rm = ($urandom_range(0, 1) == 0) ? ALL1 : {4'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) cfg_write(3'($urandom_range(0, 7)), 8'($urandom));
      run_word(rc, rm, $urandom_range(0, 3), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/fns_dec_seq.md
Name: fns_dec_seq

Overview:
- Sequencer for the FNS codeword decoder. It accepts a multi-group CAC codeword over a valid/ready handshake and decodes one 9-bit group per cycle through one shared combinational group decoder.
- Group weights come from a runtime-programmable FNS weight register file. The per-group enable mask (local AFNS flags) is applied before decode.
- The block sits between the CAC link receiver and the data sink. It returns the concatenated decoded data word over a second valid/ready handshake.

Parameters:
- NGRP, 4, number of 9-bit code groups per codeword.
- WLEN, 8, width of each programmable FNS weight.
- BLEN, 8, decoded width per group. Sum is taken modulo 2^BLEN.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  codeword offered.
- in_ready  output  1  codeword accepted when in_valid & in_ready.
- in_code  input  NGRP*9  codeword. Group g = bits [9g+8:9g].
- in_mask  input  NGRP*9  en_flag per bit. 0 forces that bit to 0 before decode.
- out_valid  output  1  decoded word available.
- out_ready  input  1  sink accepts when out_valid & out_ready.
- out_data  output  NGRP*BLEN  group g result in bits [BLEN*g+BLEN-1:BLEN*g].
- cfg_we  input  1  weight write strobe.
- cfg_addr  input  3  weight index 0..6, mapping to code bit positions 2..8.
- cfg_wdata  input  WLEN  weight value.
- cfg_drop  output  1  one-cycle pulse: the previous cycle's cfg write was rejected.
- busy  output  1  high in DEC or OUT.

Behaviour:
- Reset values:
  - state IDLE, group counter 0, out_data 0, out_valid 0, cfg_drop 0, busy 0.
  - in_ready is 0 while rst is high.
  - Weights reset to 2,3,5,8,13,21,34 for bit positions 2..8.
- Group decode function:
  - e = code & mask.
  - result = e[0] + e[1] + sum over i=2..8 of (e[i] ? W[i] : 0).
  - Bits 0 and 1 have fixed weight 1. The sum is truncated to BLEN bits.
- FSM IDLE:
  - in_ready = 1.
  - On accept, in_code and in_mask are latched, counter is cleared, and the FSM goes to DEC.
- FSM DEC:
  - in_ready = 0.
  - Each cycle, group [counter] of the latched code/mask is decoded, written into the out_data slice [counter], and the counter increments.
  - After group NGRP-1, the FSM goes to OUT.
  - Exactly NGRP cycles are spent in DEC.
- FSM OUT:
  - out_valid = 1, and out_data is held stable until out_ready.
  - On handshake, the FSM goes to IDLE and out_valid drops in the next cycle.
  - in_ready stays 0 throughout OUT; there is no overlap of codewords.
- Latency and throughput:
  - Accept at edge T; out_valid is high from cycle T+NGRP+1.
  - Minimum interval between accepts is NGRP+2 cycles.
- Weight writes:
  - Accepted only in IDLE.
  - A write in the same cycle as an input accept is committed, and that codeword decodes with the new weight.
  - A cfg_we in DEC or OUT is dropped: weights are unchanged and cfg_drop pulses the next cycle.
  - cfg_addr 7 is ignored silently, with no cfg_drop.
- out_data between words:
  - Keeps the previous word's data after the handshake.
  - Slices are overwritten only as groups decode.
- Reset mid-operation: the codeword in flight is discarded, out_valid is 0 from the next cycle, and weights return to their defaults.
- Handshake inputs are sampled only in the relevant state. in_valid in DEC or OUT has no effect.

Decomposition:
- Package fns_dec_pkg holds:
  - CW = 9 and NW = 7 (programmable weight count).
  - Default weight constants FNS03..FNS09 = 2,3,5,8,13,21,34.
  - State encoding IDLE/DEC/OUT.
- Sub-module fns_group_dec: purely combinational. Inputs are a 9-bit code, a 9-bit mask, and NW*WLEN packed weights; output is BLEN result. It is instantiated once and shared across groups via the counter mux.

Test Plan:
- Defaults, all groups code 9'h1FF, mask 9'h1FF -> each slice 0x58 (88); out_valid exactly 5 cycles after accept.
- Group0 code 9'h004, group1 code 9'h1FF with mask 9'h000, others 0 -> out_data slices 0x02, 0x00, 0x00, 0x00.
- In IDLE write addr 6 = 200, then code 9'h1FF all groups -> slices 0xFE. Then write addr 6 = 255, same code -> slices 0x35 (309 mod 256).
- out_ready held low for 6 cycles in OUT -> out_valid stays 1, out_data stable, in_ready 0. Handshake on the 7th cycle, IDLE on the next.
- cfg_we addr 0 = 99 during DEC -> cfg_drop pulses once, and the next word with code 9'h004 still decodes to 0x02.
- rst asserted on DEC cycle 2 -> out_valid never rises, in_ready returns to 1 the cycle after rst drops, and weights are back at defaults.
